// File: rtl/scoreboard_pkg.sv
// Shared types for the issue scoreboard: register index, latency and the
// per-lane instruction bundle, plus latency clamping.
package scoreboard_pkg;

  localparam int unsigned SB_LANES   = 2;
  localparam int unsigned SB_NREGS   = 32;
  localparam int unsigned SB_MAX_LAT = 8;
  localparam int unsigned SB_PCW     = 16;
  localparam int unsigned SB_RW      = $clog2(SB_NREGS);
  localparam int unsigned SB_LW      = $clog2(SB_MAX_LAT + 1);

  typedef logic [SB_RW-1:0] reg_idx_t;
  typedef logic [SB_LW-1:0] lat_t;

  typedef struct packed {
    logic     valid;
    logic     we;
    reg_idx_t rd;
    reg_idx_t rs1;
    reg_idx_t rs2;
    lat_t     lat;
  } lane_t;

  function automatic lat_t clamp_lat(input lat_t lat, input lat_t max_lat);
    if (lat == '0)
      return lat_t'(1);
    if (lat > max_lat)
      return max_lat;
    return lat;
  endfunction

endpackage

// File: rtl/sb_lat_counter.sv
// Per-register result countdown; the register is busy while the count is nonzero.
module sb_lat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/issue_scoreboard.sv
// In-order multi-lane issue scoreboard: RAW/WAW hazard checks against pending
// register writes and earlier lanes of the same bundle, plus perf counters.
module issue_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int unsigned LANES   = SB_LANES,
  parameter int unsigned NREGS   = SB_NREGS,
  parameter int unsigned MAX_LAT = SB_MAX_LAT,
  parameter int unsigned PCW     = SB_PCW,
  localparam int unsigned RW     = $clog2(NREGS),
  localparam int unsigned LW     = $clog2(MAX_LAT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [LANES-1:0]    ins_valid,
  input  logic [LANES-1:0]    ins_we,
  input  logic [LANES*RW-1:0] ins_rd,
  input  logic [LANES*RW-1:0] ins_rs1,
  input  logic [LANES*RW-1:0] ins_rs2,
  input  logic [LANES*LW-1:0] ins_lat,
  output logic [LANES-1:0]    issue,
  output logic [NREGS-1:0]    busy,
  output logic [PCW-1:0]      issue_cnt,
  output logic [PCW-1:0]      stall_cnt
);

  lane_t              lane    [LANES];
  logic [NREGS-1:0]   wmask   [LANES];
  logic [LANES-1:0]   chain;
  logic [LANES-1:0]   issue_w;
  logic [NREGS-1:1]   load;
  lat_t               load_val [1:NREGS-1];

  // wmask[k] holds the destinations written by lanes 0..k-1, so one lookup
  // covers both pending writes and same-bundle producers.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [NREGS-1:0] hz;
    logic             raw;
    logic             waw;

    assign lane[k].valid = ins_valid[k];
    assign lane[k].we    = ins_we[k];
    assign lane[k].rd    = reg_idx_t'(ins_rd[k*RW +: RW]);
    assign lane[k].rs1   = reg_idx_t'(ins_rs1[k*RW +: RW]);
    assign lane[k].rs2   = reg_idx_t'(ins_rs2[k*RW +: RW]);
    assign lane[k].lat   = lat_t'(ins_lat[k*LW +: LW]);

    if (k == 0) begin : g_first
      assign chain[k] = 1'b1;
      assign wmask[k] = '0;
    end else begin : g_rest
      assign chain[k] = issue_w[k-1];
    end

    if (k < LANES - 1) begin : g_fwd
      assign wmask[k+1] = wmask[k] |
        ((lane[k].valid && lane[k].we && lane[k].rd != '0) ?
         (NREGS'(1) << lane[k].rd) : '0);
    end

    assign hz  = busy | wmask[k];
    assign raw = hz[lane[k].rs1] | hz[lane[k].rs2];
    assign waw = lane[k].we & hz[lane[k].rd];
    assign issue_w[k] = chain[k] & lane[k].valid & ~flush & ~rst & ~raw & ~waw;
  end

  always_comb begin
    for (int unsigned r = 1; r < NREGS; r++) begin
      load[r]     = 1'b0;
      load_val[r] = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
        if (issue_w[k] && lane[k].we && lane[k].rd == reg_idx_t'(r)) begin
          load[r]     = 1'b1;
          load_val[r] = clamp_lat(lane[k].lat, lat_t'(MAX_LAT)) - lat_t'(1);
        end
      end
    end
  end

  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_reg
    sb_lat_counter #(.W(LW)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (flush),
      .load     (load[r]),
      .load_val (load_val[r]),
      .busy     (busy[r])
    );
  end

  logic [2:0]   pop;
  logic [PCW:0] isum;
  logic         stall_ev;

  always_comb begin
    pop = '0;
    for (int unsigned k = 0; k < LANES; k++)
      pop = pop + {2'b00, issue_w[k]};
  end

  assign isum     = {1'b0, issue_cnt} + {{(PCW-2){1'b0}}, pop};
  assign stall_ev = ins_valid[0] & ~flush & ~issue_w[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      issue_cnt <= isum[PCW] ? '1 : isum[PCW-1:0];
      if (stall_ev && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign issue = issue_w;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Scoreboard-driven bench for issue_scoreboard (LANES=2, NREGS=32, MAX_LAT=8).
module tb_issue_scoreboard;

  localparam int unsigned LANES = 2;
  localparam int unsigned NREGS = 32;
  localparam int unsigned RW    = 5;
  localparam int unsigned LW    = 4;
  localparam int unsigned PCW   = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic [LANES-1:0]    ins_valid, ins_we;
  logic [LANES*RW-1:0] ins_rd, ins_rs1, ins_rs2;
  logic [LANES*LW-1:0] ins_lat;
  logic [LANES-1:0]    issue;
  logic [NREGS-1:0]    busy;
  logic [PCW-1:0]      issue_cnt, stall_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [1:0]  exp_q[$];
  int unsigned m_issue, m_stall;

  issue_scoreboard #(.LANES(2), .NREGS(32), .MAX_LAT(8), .PCW(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ins_valid(ins_valid), .ins_we(ins_we),
    .ins_rd(ins_rd), .ins_rs1(ins_rs1), .ins_rs2(ins_rs2), .ins_lat(ins_lat),
    .issue(issue), .busy(busy), .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  task automatic set_lane(input int k, input bit v, input bit we,
                          input int rd, input int rs1, input int rs2, input int lat);
    logic [31:0] t;
    ins_valid[k] = v;
    ins_we[k]    = we;
    t = rd;  ins_rd[k*RW +: RW]  = t[RW-1:0];
    t = rs1; ins_rs1[k*RW +: RW] = t[RW-1:0];
    t = rs2; ins_rs2[k*RW +: RW] = t[RW-1:0];
    t = lat; ins_lat[k*LW +: LW] = t[LW-1:0];
  endtask

  task automatic idle();
    flush = 1'b0; ins_valid = '0; ins_we = '0;
    ins_rd = '0; ins_rs1 = '0; ins_rs2 = '0; ins_lat = '0;
  endtask

  // Push the expected issue vector and advance the reference counters.
  task automatic expect_issue(input logic [1:0] e);
    exp_q.push_back(e);
    m_issue += int'(e[0]) + int'(e[1]);
    if (ins_valid[0] && !flush && !e[0]) m_stall++;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    idle(); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_issue = 0; m_stall = 0; exp_q.delete();
  endtask

  task automatic test_reset();
    logic [1:0] e;
    rst = 1'b1; idle();
    set_lane(0, 1, 1, 1, 2, 3, 1);
    #2;
    n_checks++; if (issue !== 2'b00) begin n_fail++; $display("FAIL reset_issue: got %b required 00", issue); end
    n_checks++; if (busy !== '0) begin n_fail++; $display("FAIL reset_busy: got %h required 0", busy); end
    n_checks++; if (issue_cnt !== '0 || stall_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d/%0d required 0/0", issue_cnt, stall_cnt); end
    @(posedge clk); #1; rst = 1'b0; m_issue = 0; m_stall = 0;
    expect_issue(2'b01);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++; if (issue !== e) begin n_fail++; $display("FAIL reset_first_issue: got %b required %b", issue, e); end
    next(); idle();
  endtask

  task automatic test_independent();
    logic [1:0] e;
    apply_reset();
    set_lane(0, 1, 1, 1, 2, 3, 1);
    set_lane(1, 1, 1, 4, 5, 6, 1);
    expect_issue(2'b11);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++; if (issue !== e) begin n_fail++; $display("FAIL indep_issue: got %b required %b", issue, e); end
    next(); idle();
    @(negedge clk);
    n_checks++; if (issue_cnt !== 16'd2 || issue_cnt !== m_issue[PCW-1:0]) begin n_fail++; $display("FAIL indep_cnt: got %0d required 2", issue_cnt); end
    n_checks++; if (busy !== '0) begin n_fail++; $display("FAIL indep_busy: got %h required 0", busy); end
    next();
  endtask

  task automatic test_raw_bundle();
    logic [1:0] e;
    apply_reset();
    set_lane(0, 1, 1, 1, 2, 0, 1);
    set_lane(1, 1, 1, 3, 1, 0, 1);
    expect_issue(2'b01);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++; if (issue !== e) begin n_fail++; $display("FAIL raw_bundle_c0: got %b required %b", issue, e); end
    next(); idle();
    set_lane(0, 1, 1, 3, 1, 0, 1);
    expect_issue(2'b01);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++; if (issue !== e) begin n_fail++; $display("FAIL raw_bundle_c1: got %b required %b", issue, e); end
    next(); idle();
    // RAW through rs2 of an earlier lane
    set_lane(0, 1, 1, 14, 0, 0, 2);
    set_lane(1, 1, 1, 15, 0, 14, 1);
    expect_issue(2'b01);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++; if (issue !== e) begin n_fail++; $display("FAIL raw_rs2: got %b required %b", issue, e); end
    next(); idle();
    @(negedge clk);
    n_checks++; if (issue_cnt !== m_issue[PCW-1:0] || stall_cnt !== 16'd0) begin n_fail++; $display("FAIL raw_cnt: got %0d/%0d required %0d/0", issue_cnt, stall_cnt, m_issue); end
    next();
  endtask

  task automatic test_multi_cycle();
    logic [1:0] e;
    apply_reset();
    set_lane(0, 1, 1, 5, 1, 2, 4);
    expect_issue(2'b01);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++; if (issue !== e) begin n_fail++; $display("FAIL multi_c0: got %b required %b", issue, e); end
    next();
    for (int c = 1; c <= 4; c++) begin
      idle();
      set_lane(0, 1, 1, 9, 5, 0, 1);
      expect_issue(c == 4 ? 2'b01 : 2'b00);
      @(negedge clk); e = exp_q.pop_front();
      n_checks++; if (issue !== e) begin n_fail++; $display("FAIL multi_issue c%0d: got %b required %b", c, issue, e); end
      n_checks++; if (busy[5] !== (c < 4)) begin n_fail++; $display("FAIL multi_busy5 c%0d: got %b required %b", c, busy[5], c < 4); end
      next();
    end
    idle();
    @(negedge clk);
    n_checks++; if (stall_cnt !== 16'd3 || stall_cnt !== m_stall[PCW-1:0]) begin n_fail++; $display("FAIL multi_stall_cnt: got %0d required 3", stall_cnt); end
    n_checks++; if (issue_cnt !== 16'd2) begin n_fail++; $display("FAIL multi_issue_cnt: got %0d required 2", issue_cnt); end
    next();
  endtask

  task automatic test_waw_gap_clamp();
    logic [1:0] e;
    apply_reset();
    set_lane(0, 1, 1, 8, 0, 0, 3);
    set_lane(1, 1, 1, 8, 1, 1, 1);
    expect_issue(2'b01);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++; if (issue !== e) begin n_fail++; $display("FAIL waw_bundle: got %b required %b", issue, e); end
    next();
    for (int c = 1; c <= 3; c++) begin
      idle();
      set_lane(0, 1, 1, 8, 0, 0, 1);
      expect_issue(c == 3 ? 2'b01 : 2'b00);
      @(negedge clk); e = exp_q.pop_front();
      n_checks++; if (issue !== e) begin n_fail++; $display("FAIL waw_busy c%0d: got %b required %b", c, issue, e); end
      next();
    end
    idle();
    set_lane(1, 1, 1, 20, 0, 0, 1);
    expect_issue(2'b00);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++; if (issue !== e) begin n_fail++; $display("FAIL gap_lane0: got %b required %b", issue, e); end
    next(); idle();
    // lat 0 acts as 1; lat 15 is clamped to 8
    set_lane(0, 1, 1, 10, 0, 0, 0);
    set_lane(1, 1, 1, 11, 0, 0, 15);
    expect_issue(2'b11);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++; if (issue !== e) begin n_fail++; $display("FAIL clamp_c0: got %b required %b", issue, e); end
    next();
    for (int c = 1; c <= 8; c++) begin
      idle();
      if (c == 1) set_lane(0, 1, 1, 12, 10, 0, 1);
      expect_issue(c == 1 ? 2'b01 : 2'b00);
      @(negedge clk); e = exp_q.pop_front();
      n_checks++; if (issue !== e) begin n_fail++; $display("FAIL clamp_issue c%0d: got %b required %b", c, issue, e); end
      if (c == 1 || c == 7 || c == 8) begin
        n_checks++; if (busy[11] !== (c < 8)) begin n_fail++; $display("FAIL clamp_busy11 c%0d: got %b required %b", c, busy[11], c < 8); end
      end
      next();
    end
    idle();
    @(negedge clk);
    n_checks++; if (stall_cnt !== 16'd2 || issue_cnt !== m_issue[PCW-1:0]) begin n_fail++; $display("FAIL waw_cnt: got %0d/%0d required 2/%0d", stall_cnt, issue_cnt, m_issue); end
    next();
  endtask

  task automatic test_flush();
    logic [1:0] e;
    apply_reset();
    set_lane(0, 1, 1, 7, 0, 0, 8);
    expect_issue(2'b01);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++; if (issue !== e) begin n_fail++; $display("FAIL flush_c0: got %b required %b", issue, e); end
    next(); idle();
    expect_issue(2'b00);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++; if (busy[7] !== 1'b1 || issue !== e) begin n_fail++; $display("FAIL flush_c1: busy7=%b issue=%b required 1/%b", busy[7], issue, e); end
    next();
    flush = 1'b1;
    set_lane(0, 1, 1, 12, 0, 0, 1);
    set_lane(1, 1, 1, 13, 0, 0, 1);
    expect_issue(2'b00);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++; if (issue !== e) begin n_fail++; $display("FAIL flush_c2_issue: got %b required %b", issue, e); end
    next(); idle();
    set_lane(0, 1, 1, 9, 7, 0, 1);
    expect_issue(2'b01);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++; if (busy[7] !== 1'b0 || issue !== e) begin n_fail++; $display("FAIL flush_c3: busy7=%b issue=%b required 0/%b", busy[7], issue, e); end
    next(); idle();
    @(negedge clk);
    n_checks++; if (stall_cnt !== 16'd0 || issue_cnt !== 16'd2) begin n_fail++; $display("FAIL flush_cnt: got %0d/%0d required 0/2", stall_cnt, issue_cnt); end
    next();
  endtask

  task automatic test_x0_reset();
    logic [1:0] e;
    apply_reset();
    set_lane(0, 1, 1, 0, 1, 2, 8);
    set_lane(1, 1, 1, 2, 0, 0, 1);
    expect_issue(2'b11);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++; if (issue !== e) begin n_fail++; $display("FAIL x0_c0: got %b required %b", issue, e); end
    next(); idle();
    set_lane(0, 1, 1, 0, 0, 0, 8);
    set_lane(1, 1, 1, 3, 0, 0, 1);
    expect_issue(2'b11);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++; if (busy !== '0 || issue !== e) begin n_fail++; $display("FAIL x0_c1: busy=%h issue=%b required 0/%b", busy, issue, e); end
    next(); idle();
    set_lane(0, 1, 1, 13, 0, 0, 8);
    expect_issue(2'b01);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++; if (issue !== e) begin n_fail++; $display("FAIL x0_c2: got %b required %b", issue, e); end
    next(); idle();
    set_lane(0, 1, 1, 14, 13, 0, 1);
    @(negedge clk);
    n_checks++; if (busy[13] !== 1'b1 || issue !== 2'b00) begin n_fail++; $display("FAIL pre_rst: busy13=%b issue=%b required 1/00", busy[13], issue); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (busy !== '0 || issue !== 2'b00) begin n_fail++; $display("FAIL async_rst_state: busy=%h issue=%b required 0/00", busy, issue); end
    n_checks++; if (issue_cnt !== '0 || stall_cnt !== '0) begin n_fail++; $display("FAIL async_rst_cnt: got %0d/%0d required 0/0", issue_cnt, stall_cnt); end
    #1 rst = 1'b0;
    m_issue = 0; m_stall = 0; exp_q.delete();
    next();
    expect_issue(2'b01);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++; if (issue !== e || busy !== '0) begin n_fail++; $display("FAIL post_rst: issue=%b busy=%h required %b/0", issue, busy, e); end
    next(); idle();
  endtask

  initial begin
    rst = 1'b1; idle();
    test_reset();
    test_independent();
    test_raw_bundle();
    test_multi_cycle();
    test_waw_gap_clamp();
    test_flush();
    test_x0_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 SHALL have parameter LANES, default 2, number of issue lanes presented per cycle (1..4).
REQ-002 SHALL have parameter NREGS, default 32, architectural register count; RW = clog2(NREGS).
REQ-003 SHALL have parameter MAX_LAT, default 8, maximum result latency in cycles; LW = clog2(MAX_LAT+1).
REQ-004 SHALL have parameter PCW, default 16, performance-counter width.
REQ-005 SHALL have port clk  input  1  single clock for all state, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port flush  input  1  clear all pending results, suppress issue this cycle.
REQ-008 SHALL have port ins_valid  input  LANES  lane k carries an instruction.
REQ-009 SHALL have port ins_we  input  LANES  lane k writes a destination register.
REQ-010 SHALL have ports ins_rd, ins_rs1, ins_rs2  input  LANES x RW  destination/source indices per lane.
REQ-011 SHALL have port ins_lat  input  LANES x LW  result latency per lane, 1..MAX_LAT.
REQ-012 SHALL have port issue  output  LANES  lane k issued this cycle.
REQ-013 SHALL have port busy  output  NREGS  register pending-write vector.
REQ-014 SHALL have ports issue_cnt, stall_cnt  output  PCW  issued-instruction and stall-cycle counters.

Function
REQ-015 SHALL compute issue combinationally from current state and inputs (zero-cycle decision); state updates on rising clk.
REQ-016 SHALL issue lanes strictly in order: issue[k] requires issue[j] for all valid j<k.
REQ-017 SHALL block lane k on RAW: rs1 or rs2 busy, or equal to rd of an earlier valid writing lane in the same bundle.
REQ-018 SHALL block lane k on WAW: ins_we and rd busy, or equal to rd of an earlier valid writing lane in the bundle.
REQ-019 SHALL treat register 0 as never busy and never a hazard source; writes to rd=0 set nothing.
REQ-020 SHALL, on issue with ins_we and rd!=0, load that register's countdown with ins_lat-1.
REQ-021 SHALL decrement every nonzero countdown by 1 per cycle; busy[r] = (countdown[r] != 0).
REQ-022 SHALL therefore make an rd issued in cycle t with latency L readable by issue in cycle t+L (L=1: next cycle).
REQ-023 SHALL clamp ins_lat of 0 to 1 and ins_lat above MAX_LAT to MAX_LAT.
REQ-024 SHALL, when flush=1, drive issue to all zeros and zero every countdown at the next edge; flush wins over any issue.
REQ-025 SHALL add popcount(issue) to issue_cnt each cycle, saturating at all-ones.
REQ-026 SHALL increment stall_cnt (saturating) each cycle where ins_valid[0]=1, flush=0 and issue[0]=0.
REQ-027 SHALL ignore ins_rd/rs/we/lat of lanes with ins_valid=0; a gap (invalid lane) stops issue of all later lanes.

Reset
REQ-028 SHALL, while rst=1, asynchronously zero all countdowns, busy, issue_cnt and stall_cnt, and drive issue to zero.
REQ-029 SHALL, on rst asserted mid-countdown, discard all pending results; first cycle after release sees no register busy.

Structure
REQ-030 SHALL place MAX_LAT-derived latency type, register-index type and lane bundle struct in shared package scoreboard_pkg.
REQ-031 SHALL implement the per-register countdown as sub-module sb_lat_counter, instantiated NREGS-1 times (r=1..NREGS-1).
REQ-032 SHALL keep hazard and in-order logic in issue_scoreboard as a generate loop over LANES.

Verification
REQ-033 SHALL cover independent pair: lane0 add x1<-x2,x3 lat1, lane1 add x4<-x5,x6 lat1 -> issue=2'b11, issue_cnt +2.
REQ-034 SHALL cover intra-bundle RAW: lane0 x1<-x2 lat1, lane1 x3<-x1 -> issue=2'b01; next cycle lane0 x3<-x1 issues.
REQ-035 SHALL cover multi-cycle: x5 issued lat4 in cycle 0 -> busy[5]=1 cycles 1-3, reader of x5 stalls 3 cycles, issues cycle 4, stall_cnt=3.
REQ-036 SHALL cover flush: x7 issued lat8, flush in cycle 2 -> issue=0 that cycle, busy[7]=0 from cycle 3.
REQ-037 SHALL cover x0 and reset: writes to x0 with lat8 never set busy; rst pulse mid-countdown -> busy=0, counters=0 immediately.
